branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Resolution end of the branch-prediction loop. Records each predicted branch at decode and tracks it down the pipeline.
- At the memory stage, compares the prediction with the actual outcome and drives three things:
  - a mispredict redirect and pipeline flush;
  - the training update (type, outcome) back to the 2-bit-counter predictor;
  - saturating statistics counters.
- Sits beside the predictor, between the decode and memory-stage control logic.

Parameters:
- DEPTH, 2, number of pipeline stages from decode capture to memory-stage resolution (min 1).
- FLUSH_CYCLES, 2, cycles `flush` stays asserted after a mispredict (min 1).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline hold; tracking does not advance and nothing resolves
- branch_decode_sig  in  1  branch instruction present in decode
- prediction  in  1  predictor output for the decode-stage branch
- branch_type  in  3  branch type index (0-5) of the decode-stage branch
- pc_in  in  32  decode-stage branch PC
- branch_target  in  32  taken target of the decode-stage branch
- branch_mem_sig  in  1  tracked branch has reached the memory stage
- actual_branch_decision  in  1  resolved outcome, valid with branch_mem_sig
- mispredict  out  1  one-cycle pulse on a wrong prediction
- redirect_pc  out  32  correct next PC, valid while mispredict=1
- flush  out  1  squash younger instructions
- update_valid  out  1  one-cycle predictor training pulse
- update_type  out  3  type index to train
- update_taken  out  1  actual outcome to train with
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  mispredicted branches

Behaviour:
- Reset: all outputs 0, all tracking entries invalid, counters 0, state IDLE. Reset mid-FLUSH aborts to IDLE with everything cleared.
- Tracking pipe:
  - DEPTH entries, each {valid, predicted, type, target, fallthrough}. fallthrough = pc_in + 4, modulo 2^32.
  - When stall=0, entries shift one stage per cycle.
  - Entry 0 loads valid=branch_decode_sig only when state=IDLE and no mispredict is resolving this cycle; otherwise it loads invalid.
  - When stall=1, all entries hold.
- Resolution:
  - Occurs in cycle T when stall=0, branch_mem_sig=1 and the last entry is valid.
  - branch_mem_sig with an invalid last entry is ignored: no update, no count.
- Registered outputs, visible at T+1, one-cycle pulses:
  - update_valid=1, update_type = entry type, update_taken = actual_branch_decision.
  - branch_count increments, saturating at all-ones.
  - If predicted != actual_branch_decision:
    - mispredict=1.
    - redirect_pc = target if actual=1, else fallthrough.
    - mispredict_count increments, saturating.
    - All tracking entries invalidated.
    - State goes to FLUSH.
- FSM:
  - IDLE: normal operation; flush=0.
  - FLUSH: flush=1, driven from the same edge as mispredict. A down-counter loaded with FLUSH_CYCLES-1 holds the state for exactly FLUSH_CYCLES cycles, then returns to IDLE. Decode captures are suppressed.
  - The counter decrements regardless of stall.
- Simultaneous events:
  - Decode capture and mispredict in the same cycle: mispredict wins and the capture is discarded.
  - Resolution while stall=1: deferred until stall drops, with inputs sampled then.
- Correct prediction: update_valid pulses; mispredict and flush stay 0.

Decomposition:
- Shared package holds:
  - NUM_BRANCH_TYPES = 6;
  - BRANCH_TYPE_W = 3;
  - FSM state encoding (IDLE=0, FLUSH=1);
  - PC_INCR = 4.
- One sub-module: branch_track_entry, a single pipeline register slot with valid/hold/clear. It is instantiated DEPTH times.
- Saturating counters stay inline.

Test Plan:
- Predict-correct path:
  - Stimulus: reset; decode branch pc=0x100, target=0x180, prediction=1, type=2; 2 cycles later branch_mem_sig=1, actual=1.
  - Response: next cycle update_valid=1, update_type=2, update_taken=1, mispredict=0, flush=0, branch_count=1.
- Mispredict not-taken:
  - Stimulus: pc=0x200, target=0x300, prediction=1; resolves actual=0.
  - Response: mispredict=1, redirect_pc=0x204, flush=1 for exactly 2 cycles, mispredict_count=1.
- Mispredict taken, with wrap:
  - Stimulus: pc=0xFFFFFFFC, target=0x40, prediction=0; resolves actual=1.
  - Response: redirect_pc=0x40.
  - Repeat with target irrelevant and actual=0: response redirect_pc=0x00000000.
- Stall:
  - Stimulus: branch captured, then stall=1 for 3 cycles with branch_mem_sig=1 throughout.
  - Response: no update during the stall; resolution occurs the first cycle after stall drops.
- Flush collision:
  - Stimulus: branch_decode_sig=1 in the resolving-mispredict cycle and during FLUSH.
  - Response: no entry captured; a later branch_mem_sig produces no update_valid.
- Saturation/reset:
  - Stimulus: force counters to all-ones minus 1, resolve 2 mispredicts.
  - Response: both counters stick at all-ones.
  - Stimulus: reset asserted in the middle of FLUSH.
  - Response: flush=0 and counters=0 the next cycle.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolution block.
// Holds the tracking-entry layout and the resolver FSM encoding.
package branch_resolver_pkg;

  localparam int          NUM_BRANCH_TYPES = 6;
  localparam int          BRANCH_TYPE_W    = 3;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic                     predicted;
    logic [BRANCH_TYPE_W-1:0] btype;
    logic [31:0]              target;
    logic [31:0]              fallthrough;
  } entry_t;

endpackage

// File: rtl/branch_track_entry.sv
// One slot of the branch tracking pipe: loads d unless held; clear wins over hold.
module branch_track_entry
  import branch_resolver_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   clear,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Tracks predicted branches from decode to memory stage, resolves them, and
// drives redirect/flush, predictor training and saturating statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     branch_decode_sig,
  input  logic                     prediction,
  input  logic [BRANCH_TYPE_W-1:0] branch_type,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              branch_target,
  input  logic                     branch_mem_sig,
  input  logic                     actual_branch_decision,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic                     flush,
  output logic                     update_valid,
  output logic [BRANCH_TYPE_W-1:0] update_type,
  output logic                     update_taken,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count,
  output state_t                   fsm_state
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t          state, state_next;
  logic [FC_W-1:0] flush_cnt, flush_cnt_next;
  entry_t          stage_q [DEPTH];
  entry_t          capture;
  entry_t          last;
  logic            resolve;
  logic            wrong;

  assign last    = stage_q[DEPTH-1];
  assign resolve = !stall && branch_mem_sig && last.valid;
  assign wrong   = resolve && (last.predicted != actual_branch_decision);

  // A resolving mispredict discards the branch sitting in decode this cycle.
  always_comb begin
    capture             = '0;
    capture.valid       = branch_decode_sig && (state == IDLE) && !wrong;
    capture.predicted   = prediction;
    capture.btype       = branch_type;
    capture.target      = branch_target;
    capture.fallthrough = pc_in + PC_INCR;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      branch_track_entry u_entry (
        .clk   (clk),
        .reset (reset),
        .hold  (stall),
        .clear (wrong),
        .d     (capture),
        .q     (stage_q[0])
      );
    end else begin : g_tail
      branch_track_entry u_entry (
        .clk   (clk),
        .reset (reset),
        .hold  (stall),
        .clear (wrong),
        .d     (stage_q[i-1]),
        .q     (stage_q[i])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // The flush window counts down every cycle, stalled or not.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (wrong) begin
      state_next     = FLUSH;
      flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      if (flush_cnt == '0) begin
        state_next = IDLE;
      end else begin
        flush_cnt_next = flush_cnt - FC_W'(1);
      end
    end
  end

  assign flush     = (state == FLUSH);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      update_valid     <= 1'b0;
      update_type      <= '0;
      update_taken     <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      update_valid <= resolve;
      mispredict   <= wrong;
      if (resolve) begin
        update_type  <= last.btype;
        update_taken <= actual_branch_decision;
        if (branch_count != '1) begin
          branch_count <= branch_count + CNT_W'(1);
        end
      end
      if (wrong) begin
        redirect_pc <= actual_branch_decision ? last.target : last.fallthrough;
        if (mispredict_count != '1) begin
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table plus random traffic checked
// against a slot-array reference model; a narrow-counter copy exercises saturation.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int DEPTH = 2;
  localparam int FLUSH_CYCLES = 2;

  logic        clk;
  logic        reset, stall, branch_decode_sig, prediction, branch_mem_sig, actual_branch_decision;
  logic [2:0]  branch_type;
  logic [31:0] pc_in, branch_target;

  logic        mispredict, flush, update_valid, update_taken;
  logic [31:0] redirect_pc, branch_count, mispredict_count;
  logic [2:0]  update_type;
  state_t      fsm_state;

  logic        s_mispredict, s_flush, s_update_valid, s_update_taken;
  logic [31:0] s_redirect_pc;
  logic [2:0]  s_update_type;
  logic [1:0]  s_branch_count, s_mispredict_count;
  state_t      s_fsm_state;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_decode_sig(branch_decode_sig),
    .prediction(prediction), .branch_type(branch_type), .pc_in(pc_in),
    .branch_target(branch_target), .branch_mem_sig(branch_mem_sig),
    .actual_branch_decision(actual_branch_decision), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .flush(flush), .update_valid(update_valid),
    .update_type(update_type), .update_taken(update_taken), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .fsm_state(fsm_state)
  );

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .branch_decode_sig(branch_decode_sig),
    .prediction(prediction), .branch_type(branch_type), .pc_in(pc_in),
    .branch_target(branch_target), .branch_mem_sig(branch_mem_sig),
    .actual_branch_decision(actual_branch_decision), .mispredict(s_mispredict),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .update_valid(s_update_valid),
    .update_type(s_update_type), .update_taken(s_update_taken), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count), .fsm_state(s_fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    bit        rst, stl, dec, pred;
    bit [2:0]  typ;
    bit [31:0] pc, tgt;
    bit        mem, act;
    bit        e_mis, e_flush, e_upd, e_taken;
    bit [2:0]  e_type;
    bit [31:0] e_red, e_bc, e_mc;
  } vec_t;

  function automatic vec_t v_nop(bit fl, int bc, int mc);
    vec_t t = '0;
    t.e_flush = fl;
    t.e_bc = bc;
    t.e_mc = mc;
    return t;
  endfunction

  function automatic vec_t v_dec(bit [31:0] pc, bit [31:0] tgt, bit pred, bit [2:0] typ,
                                 bit fl, int bc, int mc);
    vec_t t = v_nop(fl, bc, mc);
    t.dec = 1'b1;
    t.pc = pc;
    t.tgt = tgt;
    t.pred = pred;
    t.typ = typ;
    return t;
  endfunction

  function automatic vec_t v_res(bit act, bit mis, bit [2:0] typ, bit [31:0] red, int bc, int mc);
    vec_t t = v_nop(mis, bc, mc);
    t.mem = 1'b1;
    t.act = act;
    t.e_upd = 1'b1;
    t.e_taken = act;
    t.e_type = typ;
    t.e_mis = mis;
    t.e_red = red;
    return t;
  endfunction

  // reference model: in-flight branch slots, remaining flush cycles, event totals
  typedef struct packed {
    bit        v, pred;
    bit [2:0]  typ;
    bit [31:0] tgt, pc;
  } slot_t;

  slot_t     m_slot [DEPTH];
  int        m_flush_left;
  longint    m_bc, m_mc;
  bit        m_mis, m_upd, m_taken;
  bit [2:0]  m_type;
  bit [31:0] m_red;

  function automatic longint sat(longint x, longint top);
    return (x > top) ? top : x;
  endfunction

  task automatic model_step(input vec_t t);
    bit    idle;
    slot_t old;
    if (t.rst) begin
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
      m_flush_left = 0;
      m_bc = 0;
      m_mc = 0;
      m_mis = 0;
      m_upd = 0;
      m_taken = 0;
      m_type = 0;
      m_red = 0;
      return;
    end
    idle = (m_flush_left == 0);
    m_mis = 0;
    m_upd = 0;
    old = m_slot[DEPTH-1];
    if (!t.stl && t.mem && old.v) begin
      m_upd = 1;
      m_type = old.typ;
      m_taken = t.act;
      m_bc++;
      if (old.pred != t.act) begin
        m_mis = 1;
        m_mc++;
        m_red = t.act ? old.tgt : old.pc + 32'd4;
      end
    end
    if (m_flush_left > 0) m_flush_left--;
    if (m_mis) begin
      m_flush_left = FLUSH_CYCLES;
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
    end else if (!t.stl) begin
      for (int i = DEPTH - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
      m_slot[0] = '{v: t.dec && idle, pred: t.pred, typ: t.typ, tgt: t.tgt, pc: t.pc};
    end
  endtask

  task automatic check_model();
    chk("mdl_mispredict", 32'(mispredict), 32'(m_mis));
    chk("mdl_flush", 32'(flush), 32'(m_flush_left > 0));
    chk("mdl_fsm_state", 32'(fsm_state), 32'(m_flush_left > 0));
    chk("mdl_update_valid", 32'(update_valid), 32'(m_upd));
    if (m_upd) begin
      chk("mdl_update_type", 32'(update_type), 32'(m_type));
      chk("mdl_update_taken", 32'(update_taken), 32'(m_taken));
    end
    if (m_mis) chk("mdl_redirect_pc", redirect_pc, m_red);
    chk("mdl_branch_count", branch_count, 32'(sat(m_bc, 64'hFFFF_FFFF)));
    chk("mdl_mispredict_count", mispredict_count, 32'(sat(m_mc, 64'hFFFF_FFFF)));
    chk("mdl_sat_mispredict", 32'(s_mispredict), 32'(m_mis));
    chk("mdl_sat_branch_count", 32'(s_branch_count), 32'(sat(m_bc, 3)));
    chk("mdl_sat_mispredict_count", 32'(s_mispredict_count), 32'(sat(m_mc, 3)));
  endtask

  task automatic check_tab(input vec_t t, input int row);
    string r;
    r = $sformatf("row%0d", row);
    chk({r, "_mispredict"}, 32'(mispredict), 32'(t.e_mis));
    chk({r, "_flush"}, 32'(flush), 32'(t.e_flush));
    chk({r, "_update_valid"}, 32'(update_valid), 32'(t.e_upd));
    if (t.e_upd) begin
      chk({r, "_update_type"}, 32'(update_type), 32'(t.e_type));
      chk({r, "_update_taken"}, 32'(update_taken), 32'(t.e_taken));
    end
    if (t.e_mis) chk({r, "_redirect_pc"}, redirect_pc, t.e_red);
    chk({r, "_branch_count"}, branch_count, t.e_bc);
    chk({r, "_mispredict_count"}, mispredict_count, t.e_mc);
    chk({r, "_sat_branch_count"}, 32'(s_branch_count), 32'(sat(longint'(t.e_bc), 3)));
    chk({r, "_sat_mispredict_count"}, 32'(s_mispredict_count), 32'(sat(longint'(t.e_mc), 3)));
  endtask

  // driver: apply one cycle of inputs, then check just after the edge
  task automatic run_cycle(input vec_t t, input bit use_tab, input int row);
    reset = t.rst;
    stall = t.stl;
    branch_decode_sig = t.dec;
    prediction = t.pred;
    branch_type = t.typ;
    pc_in = t.pc;
    branch_target = t.tgt;
    branch_mem_sig = t.mem;
    actual_branch_decision = t.act;
    @(posedge clk);
    #1;
    model_step(t);
    check_model();
    if (use_tab) check_tab(t, row);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t t;
    reset = 1'b1;
    stall = 1'b0;
    branch_decode_sig = 1'b0;
    prediction = 1'b0;
    branch_type = '0;
    pc_in = '0;
    branch_target = '0;
    branch_mem_sig = 1'b0;
    actual_branch_decision = 1'b0;

    // reset and correct prediction
    t = v_nop(0, 0, 0); t.rst = 1; vecs.push_back(t);
    vecs.push_back(v_nop(0, 0, 0));
    vecs.push_back(v_dec(32'h100, 32'h180, 1, 3'd2, 0, 0, 0));
    vecs.push_back(v_nop(0, 0, 0));
    vecs.push_back(v_res(1, 0, 3'd2, 32'h0, 1, 0));
    vecs.push_back(v_nop(0, 1, 0));
    // mispredict not-taken, two flush cycles
    vecs.push_back(v_dec(32'h200, 32'h300, 1, 3'd1, 0, 1, 0));
    vecs.push_back(v_nop(0, 1, 0));
    vecs.push_back(v_res(0, 1, 3'd1, 32'h204, 2, 1));
    vecs.push_back(v_nop(1, 2, 1));
    vecs.push_back(v_nop(0, 2, 1));
    // mispredict taken from the top of the address space, then fallthrough wrap
    vecs.push_back(v_dec(32'hFFFF_FFFC, 32'h40, 0, 3'd3, 0, 2, 1));
    vecs.push_back(v_nop(0, 2, 1));
    vecs.push_back(v_res(1, 1, 3'd3, 32'h40, 3, 2));
    vecs.push_back(v_nop(1, 3, 2));
    vecs.push_back(v_nop(0, 3, 2));
    vecs.push_back(v_dec(32'hFFFF_FFFC, 32'h1234_5678, 1, 3'd4, 0, 3, 2));
    vecs.push_back(v_nop(0, 3, 2));
    vecs.push_back(v_res(0, 1, 3'd4, 32'h0, 4, 3));
    vecs.push_back(v_nop(1, 4, 3));
    vecs.push_back(v_nop(0, 4, 3));
    // stall defers resolution; early mem_sig on an empty last slot is ignored
    vecs.push_back(v_dec(32'h400, 32'h500, 1, 3'd5, 0, 4, 3));
    t = v_nop(0, 4, 3); t.mem = 1; t.act = 1; vecs.push_back(t);
    t.stl = 1;
    for (int i = 0; i < 3; i++) vecs.push_back(t);
    vecs.push_back(v_res(1, 0, 3'd5, 32'h0, 5, 3));
    vecs.push_back(v_nop(0, 5, 3));
    // decode during the mispredict cycle and during flush is discarded
    vecs.push_back(v_dec(32'h600, 32'h700, 0, 3'd0, 0, 5, 3));
    vecs.push_back(v_nop(0, 5, 3));
    t = v_res(1, 1, 3'd0, 32'h700, 6, 4);
    t.dec = 1; t.pc = 32'h800; t.tgt = 32'h880; t.pred = 1; t.typ = 3'd1;
    vecs.push_back(t);
    vecs.push_back(v_dec(32'h900, 32'h980, 1, 3'd1, 1, 6, 4));
    vecs.push_back(v_dec(32'hA00, 32'hA80, 1, 3'd1, 0, 6, 4));
    t = v_nop(0, 6, 4); t.mem = 1; t.act = 1;
    vecs.push_back(t);
    vecs.push_back(t);
    // reset in the middle of a flush window
    vecs.push_back(v_dec(32'h900, 32'h990, 1, 3'd2, 0, 6, 4));
    vecs.push_back(v_nop(0, 6, 4));
    vecs.push_back(v_res(0, 1, 3'd2, 32'h904, 7, 5));
    t = v_nop(0, 0, 0); t.rst = 1; vecs.push_back(t);
    vecs.push_back(v_nop(0, 0, 0));

    foreach (vecs[i]) run_cycle(vecs[i], 1'b1, i);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      t = '0;
      t.rst = ($urandom_range(0, 199) == 0);
      t.stl = ($urandom_range(0, 4) == 0);
      t.dec = $urandom_range(0, 1);
      t.pred = $urandom_range(0, 1);
      t.typ = 3'($urandom_range(0, NUM_BRANCH_TYPES - 1));
      t.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      t.tgt = $urandom & 32'hFFFF_FFFC;
      t.mem = ($urandom_range(0, 9) < 6);
      t.act = $urandom_range(0, 1);
      run_cycle(t, 1'b0, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
